systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Sequencer for an N x N output-stationary systolic array of multiply-accumulate PEs (8-bit operands, 16-bit accumulators).
- Per job it does four things in order:
  - clears the array through the PEs' active-low reset;
  - drives skewed row/column feed enables for k_len operand pairs;
  - waits for the wavefront to drain;
  - walks result rows out over a valid/ready handshake.
- Sits between the host start/done interface and the A/B operand feeders plus the result-row mux.

Parameters:
- N, 4, array dimension (rows = columns); N >= 2.
- K_W, 8, width of k_len (inner dimension, 1..2^K_W-1).
- CNT_W, 10, width of feed_cnt; must hold K_MAX+N-2.
- ROW_W, 2, width of out_row; equals clog2(N).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  job request; sampled only in IDLE.
- k_len  input  K_W  inner dimension; latched when start is accepted.
- busy  output  1  high from the cycle after start acceptance through DONE.
- done  output  1  one-cycle pulse in DONE.
- err  output  1  one-cycle pulse when start is sampled in IDLE with k_len==0.
- pe_clr_n  output  1  active-low clear to all PE resets; registered, glitch-free.
- feed_cnt  output  CNT_W  feed-phase cycle index, used by the feeders as their address base.
- row_valid  output  N  bit i enables the A feeder for row i; a feeder outputs 0 when its bit is disabled.
- col_valid  output  N  bit j enables the B feeder for column j; same zero-when-disabled rule.
- out_valid  output  1  a result row is presented.
- out_row  output  ROW_W  index of the result row being presented.
- out_ready  input  1  consumer accepts the row when out_valid && out_ready.

Behaviour:
- Reset values (rst high, asynchronous):
  - State IDLE, all counters 0.
  - busy=0, done=0, err=0, out_valid=0, out_row=0, feed_cnt=0, row_valid=0, col_valid=0.
  - pe_clr_n=0 while rst is high; goes to 1 on the first clock edge after rst falls.
- rst asserted mid-job aborts immediately to these values; there is no resume.
- All outputs are registered. One FSM: IDLE -> CLEAR -> FEED -> DRAIN -> READ -> DONE -> IDLE.
- IDLE:
  - start && k_len!=0: latch K=k_len, go to CLEAR.
  - start && k_len==0: err=1 for one cycle, stay in IDLE.
  - start outside IDLE is ignored; no queuing.
- CLEAR:
  - Exactly 1 cycle with pe_clr_n=0, which zeroes the PE accumulators and forwarding registers.
  - pe_clr_n=1 in every other state.
- FEED:
  - K+N-1 cycles; feed_cnt counts 0..K+N-2.
  - row_valid[i] = (feed_cnt >= i) && (feed_cnt < i+K); col_valid[j] uses the same rule with j.
  - This skews row i and column j so PE(i,j) sees operand pair k at feed cycle k+i+j.
- DRAIN:
  - N-1 cycles with row_valid=col_valid=0 and feed_cnt held at 0.
  - After this, PE(N-1,N-1) has accumulated its last product.
- READ:
  - out_valid=1, out_row starts at 0.
  - On out_valid && out_ready, out_row increments; if the accepted row is N-1, go to DONE and drop out_valid.
  - If out_ready stays low, hold out_row and out_valid indefinitely; there is no timeout.
  - The array is not clocked differently during READ. Zero inputs add 0, so results stay stable.
- DONE: 1 cycle, done=1, busy=1; then IDLE with busy=0.
- Timing from the start edge E0:
  - CLEAR occupies E0..E1.
  - FEED occupies E1..E(K+N).
  - DRAIN ends at E(K+2N-1).
  - out_valid first rises after edge E(K+2N-1).
- Widths:
  - Counter compares use CNT_W unsigned arithmetic, with K zero-extended.
  - No wrap-around is allowed; K_MAX+N-2 < 2^CNT_W is a parameter legality rule, checked by an elaboration assertion.
- Simultaneous start and rst: rst wins.
- A start pulse arriving in the same cycle as done is ignored, because the FSM is not yet in IDLE.

Test Plan:
- Reset, then idle:
  - Stimulus: assert rst, release, hold start low.
  - Required: all outputs at reset values; pe_clr_n=0 during rst and 1 one cycle after release; busy stays 0.
- Nominal job (N=4, k_len=3, out_ready=1):
  - Required: pe_clr_n low exactly 1 cycle.
  - feed_cnt runs 0..5.
  - row_valid per cycle: 0001, 0011, 0111, 1110, 1100, 1000 (col_valid identical).
  - 3 DRAIN cycles; out_valid rises after edge E10.
  - out_row runs 0,1,2,3 on consecutive cycles, then done pulses once and busy falls.
- Backpressure:
  - Stimulus: same job with out_ready low for 5 cycles on row 2.
  - Required: out_row holds at 2 with out_valid high; the sequence resumes on ready; done follows row 3 acceptance.
- Illegal and ignored starts:
  - Stimulus: k_len=0 with start in IDLE.
  - Required: err pulses 1 cycle, busy stays 0.
  - Stimulus: start reasserted during FEED with k_len=7.
  - Required: no effect; the job completes with the original K=3 timing.
- Abort:
  - Stimulus: assert rst at feed_cnt=2 of a k_len=5 job.
  - Required: immediate return to reset values; a following start with k_len=1 runs cleanly, with FEED of 4 cycles, row_valid showing one-hot bits 0,1,2,3, and done.
- Boundary K=255, N=4:
  - Required: feed_cnt reaches 257 without overflow.
  - row_valid[3] is high for feed_cnt 3..257; row_valid[0] is high for feed_cnt 0..254.
  - The check passes under both out_ready patterns.

Source files
------------

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
// Sequencer for an N x N output-stationary systolic MAC array.
// Per job it clears the array, drives skewed row/column feed enables for
// K operand pairs, waits for the wavefront to drain, and then presents the
// result rows one at a time over a valid/ready handshake.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset (aborts any job)
//   start      - job request, sampled only while idle
//   k_len      - inner dimension K, latched when start is accepted
//   busy       - high from the cycle after start acceptance through DONE
//   done       - one-cycle completion pulse
//   err        - one-cycle pulse when start arrives with k_len == 0
//   pe_clr_n   - active-low clear for every PE, low for exactly one cycle
//   feed_cnt   - feed-phase cycle index (address base for the feeders)
//   row_valid  - per-row A feeder enables
//   col_valid  - per-column B feeder enables
//   out_valid  - a result row is presented
//   out_row    - index of the presented result row
//   out_ready  - consumer accepts the row when out_valid && out_ready
// -----------------------------------------------------------------------------
module systolic_ctrl #(
    parameter int N     = 4,
    parameter int K_W   = 8,
    parameter int CNT_W = 10,
    parameter int ROW_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [K_W-1:0]   k_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             pe_clr_n,
    output logic [CNT_W-1:0] feed_cnt,
    output logic [N-1:0]     row_valid,
    output logic [N-1:0]     col_valid,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    input  logic             out_ready
);

    // Parameter legality: the feed counter must reach K_MAX+N-2 without
    // wrapping, and the row index must be exactly wide enough for N rows.
    generate
        if (N < 2) begin : g_bad_n
            $error("systolic_ctrl: N must be at least 2");
        end
        if (((2 ** K_W) - 1 + N - 2) >= (2 ** CNT_W)) begin : g_bad_cnt_w
            $error("systolic_ctrl: CNT_W too narrow for K_MAX+N-2");
        end
        if (ROW_W != $clog2(N)) begin : g_bad_row_w
            $error("systolic_ctrl: ROW_W must equal clog2(N)");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_READ  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 2);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N - 1);

    state_t             state_r;
    state_t             state_s;
    logic [K_W-1:0]     k_r;
    logic [K_W-1:0]     k_s;
    logic [CNT_W-1:0]   feed_cnt_s;
    logic [CNT_W-1:0]   feed_last_s;
    logic [CNT_W-1:0]   drain_cnt_r;
    logic [CNT_W-1:0]   drain_cnt_s;
    logic [ROW_W-1:0]   out_row_s;
    logic               err_s;
    logic [N-1:0]       valid_s;

    // Next-state and next-counter logic for the job sequencer.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        feed_cnt_s  = {CNT_W{1'b0}};
        drain_cnt_s = {CNT_W{1'b0}};
        out_row_s   = out_row;
        err_s       = 1'b0;
        // Last feed index K+N-2; K is zero-extended into the counter width.
        feed_last_s = CNT_W'(k_r) + CNT_W'(N - 2);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (k_len != {K_W{1'b0}}) begin
                        k_s     = k_len;
                        state_s = ST_CLEAR;
                    end else begin
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_s = ST_FEED;
            end
            ST_FEED: begin
                if (feed_cnt == feed_last_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    feed_cnt_s = feed_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    state_s   = ST_READ;
                    out_row_s = {ROW_W{1'b0}};
                end else begin
                    drain_cnt_s = drain_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_READ: begin
                if (out_ready) begin
                    if (out_row == ROW_LAST) begin
                        state_s   = ST_DONE;
                        out_row_s = {ROW_W{1'b0}};
                    end else begin
                        out_row_s = out_row + {{(ROW_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    out_row_s = out_row;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Skewed feed enables: lane i is live for feed indices i..i+K-1.
    // Written as (cnt - i) < K so that i+K can never wrap the counter.
    always_comb begin
        valid_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if ((state_s == ST_FEED) && (feed_cnt_s >= CNT_W'(i))) begin
                valid_s[i] = ((feed_cnt_s - CNT_W'(i)) < CNT_W'(k_s));
            end else begin
                valid_s[i] = 1'b0;
            end
        end
    end

    // State, counters and registered outputs, all derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            k_r         <= {K_W{1'b0}};
            drain_cnt_r <= {CNT_W{1'b0}};
            feed_cnt    <= {CNT_W{1'b0}};
            out_row     <= {ROW_W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            pe_clr_n    <= 1'b0;
            out_valid   <= 1'b0;
            row_valid   <= {N{1'b0}};
            col_valid   <= {N{1'b0}};
        end else begin
            state_r     <= state_s;
            k_r         <= k_s;
            drain_cnt_r <= drain_cnt_s;
            feed_cnt    <= feed_cnt_s;
            out_row     <= out_row_s;
            busy        <= (state_s != ST_IDLE);
            done        <= (state_s == ST_DONE);
            err         <= err_s;
            pe_clr_n    <= (state_s != ST_CLEAR);
            out_valid   <= (state_s == ST_READ);
            row_valid   <= valid_s;
            col_valid   <= valid_s;
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
// Directed bench for systolic_ctrl (N=4). Inputs change and outputs are
// sampled on the falling edge; expected values are hand-derived tables or
// the skew rule evaluated from the feed index.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int N     = 4;
    localparam int K_W   = 8;
    localparam int CNT_W = 10;
    localparam int ROW_W = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic [K_W-1:0]   k_len;
    logic             busy;
    logic             done;
    logic             err;
    logic             pe_clr_n;
    logic [CNT_W-1:0] feed_cnt;
    logic [N-1:0]     row_valid;
    logic [N-1:0]     col_valid;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    // Hand-derived row/col enables for K=3, feed indices 0..5.
    logic [3:0] rv3 [6];

    systolic_ctrl #(.N(N), .K_W(K_W), .CNT_W(CNT_W), .ROW_W(ROW_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pe_clr_n  (pe_clr_n),
        .feed_cnt  (feed_cnt),
        .row_valid (row_valid),
        .col_valid (col_valid),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_ready (out_ready)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] skew_exp(input int c, input int k);
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 0; i < N; i++) begin
            v[i] = (c >= i) && (c < i + k);
        end
        return v;
    endfunction

    task automatic check_reset_vals;
        check("rst.busy",      busy,      32'd0);
        check("rst.done",      done,      32'd0);
        check("rst.err",       err,       32'd0);
        check("rst.pe_clr_n",  pe_clr_n,  32'd0);
        check("rst.feed_cnt",  feed_cnt,  32'd0);
        check("rst.row_valid", row_valid, 32'd0);
        check("rst.col_valid", col_valid, 32'd0);
        check("rst.out_valid", out_valid, 32'd0);
        check("rst.out_row",   out_row,   32'd0);
    endtask

    // Full job with optional stall on one result row and an optional
    // ignored start pulse during FEED.
    task automatic run_job(input int k, input int stall_row, input int stall_len, input bit poke);
        logic [3:0] exp_v;
        start = 1'b1;
        k_len = k[7:0];
        tick;
        start = 1'b0;
        k_len = 8'd0;
        // CLEAR
        check("clr.pe_clr_n",  pe_clr_n,  32'd0);
        check("clr.busy",      busy,      32'd1);
        check("clr.row_valid", row_valid, 32'd0);
        tick;
        // FEED
        for (int c = 0; c <= k + N - 2; c++) begin
            if (k == 3) begin
                exp_v = rv3[c];
            end else begin
                exp_v = skew_exp(c, k);
            end
            check("feed.feed_cnt",  feed_cnt,  c);
            check("feed.row_valid", row_valid, {28'd0, exp_v});
            check("feed.col_valid", col_valid, {28'd0, exp_v});
            check("feed.pe_clr_n",  pe_clr_n,  32'd1);
            check("feed.out_valid", out_valid, 32'd0);
            if (poke && (c == 2)) begin
                start = 1'b1;
                k_len = 8'd7;
            end else begin
                start = 1'b0;
                k_len = 8'd0;
            end
            tick;
        end
        start = 1'b0;
        // DRAIN
        for (int d = 0; d < N - 1; d++) begin
            check("drain.row_valid", row_valid, 32'd0);
            check("drain.feed_cnt",  feed_cnt,  32'd0);
            check("drain.out_valid", out_valid, 32'd0);
            check("drain.busy",      busy,      32'd1);
            tick;
        end
        // READ
        for (int r = 0; r < N; r++) begin
            check("read.out_valid", out_valid, 32'd1);
            check("read.out_row",   out_row,   r);
            check("read.done",      done,      32'd0);
            if (r == stall_row) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick;
                    check("stall.out_valid", out_valid, 32'd1);
                    check("stall.out_row",   out_row,   r);
                end
                out_ready = 1'b1;
            end
            tick;
        end
        // DONE
        check("done.done",      done,      32'd1);
        check("done.busy",      busy,      32'd1);
        check("done.out_valid", out_valid, 32'd0);
        tick;
        check("idle.done", done, 32'd0);
        check("idle.busy", busy, 32'd0);
        check("idle.err",  err,  32'd0);
    endtask

    initial begin
        rv3[0] = 4'b0001;
        rv3[1] = 4'b0011;
        rv3[2] = 4'b0111;
        rv3[3] = 4'b1110;
        rv3[4] = 4'b1100;
        rv3[5] = 4'b1000;

        rst       = 1'b1;
        start     = 1'b0;
        k_len     = 8'd0;
        out_ready = 1'b1;

        // Reset and idle
        #2;
        check_reset_vals();
        tick;
        tick;
        check("rst.hold_pe_clr_n", pe_clr_n, 32'd0);
        rst = 1'b0;
        #1;
        check("rel.pe_clr_n_before_edge", pe_clr_n, 32'd0);
        tick;
        check("rel.pe_clr_n", pe_clr_n, 32'd1);
        check("rel.busy",     busy,     32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("idle.busy", busy, 32'd0);
        end

        // Zero-length start
        start = 1'b1;
        k_len = 8'd0;
        tick;
        start = 1'b0;
        check("err.err",      err,      32'd1);
        check("err.busy",     busy,     32'd0);
        check("err.pe_clr_n", pe_clr_n, 32'd1);
        tick;
        check("err.err_clear", err,  32'd0);
        check("err.busy_idle", busy, 32'd0);

        // Nominal, backpressure, ignored start during FEED
        run_job(3, -1, 0, 1'b0);
        run_job(3, 2, 5, 1'b0);
        run_job(3, -1, 0, 1'b1);

        // Abort at feed_cnt=2 of a K=5 job
        start = 1'b1;
        k_len = 8'd5;
        tick;
        start = 1'b0;
        k_len = 8'd0;
        tick;
        tick;
        tick;
        check("abort.feed_cnt", feed_cnt, 32'd2);
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.pe_clr_n_low", pe_clr_n, 32'd0);
        tick;
        check("abort.pe_clr_n", pe_clr_n, 32'd1);
        check("abort.busy",     busy,     32'd0);
        run_job(1, -1, 0, 1'b0);

        // Boundary K=255 under both ready patterns
        run_job(255, -1, 0, 1'b0);
        run_job(255, 1, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
